// File: rtl/xif_offload_tracker.sv
// X-IF offload tracker: sits between the core-side and coprocessor-side X-IF.
// Keeps a per-ID scoreboard of in-flight offloads, caps the number of
// outstanding instructions, buffers committed results in a small FIFO, drops
// results for killed/unknown IDs and flags coprocessor stalls with a watchdog.
module xif_offload_tracker #(
  parameter int ID_WIDTH        = 4,
  parameter int NUM_OUTSTANDING = 2,
  parameter int RESULT_DEPTH    = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   c_issue_valid_i,
  output logic                                   c_issue_ready_o,
  input  logic [ID_WIDTH-1:0]                    c_issue_id_i,
  output logic                                   c_issue_accept_o,
  output logic                                   c_issue_writeback_o,
  output logic                                   x_issue_valid_o,
  input  logic                                   x_issue_ready_i,
  output logic [ID_WIDTH-1:0]                    x_issue_id_o,
  input  logic                                   x_issue_accept_i,
  input  logic                                   x_issue_writeback_i,
  input  logic                                   c_commit_valid_i,
  input  logic [ID_WIDTH-1:0]                    c_commit_id_i,
  input  logic                                   c_commit_kill_i,
  output logic                                   x_commit_valid_o,
  output logic [ID_WIDTH-1:0]                    x_commit_id_o,
  output logic                                   x_commit_kill_o,
  input  logic                                   x_result_valid_i,
  output logic                                   x_result_ready_o,
  input  logic [ID_WIDTH-1:0]                    x_result_id_i,
  input  logic [DATA_WIDTH-1:0]                  x_result_data_i,
  input  logic [4:0]                             x_result_rd_i,
  input  logic                                   x_result_we_i,
  output logic                                   c_result_valid_o,
  input  logic                                   c_result_ready_i,
  output logic [ID_WIDTH-1:0]                    c_result_id_o,
  output logic [DATA_WIDTH-1:0]                  c_result_data_o,
  output logic [4:0]                             c_result_rd_o,
  output logic                                   c_result_we_o,
  output logic [$clog2(NUM_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   stray_result_o,
  output logic                                   timeout_o
);

  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam int OW      = $clog2(NUM_OUTSTANDING + 1);
  localparam int PW      = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CW      = $clog2(RESULT_DEPTH + 1);

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2
  } entry_t;

  entry_t entry_q [NUM_IDS];
  entry_t entry_d [NUM_IDS];
  entry_t res_state;

  logic [OW-1:0] out_next;
  logic          issue_blocked;
  logic          issue_fire;
  logic          commit_fire;
  logic          res_hs;
  logic          res_push;
  logic          res_drop;
  logic          fifo_pop;
  logic          fifo_full;

  logic [ID_WIDTH-1:0]   fifo_id   [RESULT_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [RESULT_DEPTH];
  logic [4:0]            fifo_rd   [RESULT_DEPTH];
  logic                  fifo_we   [RESULT_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         fifo_cnt_next;

  // Straight pass-through of accept/writeback, issue ID and the commit interface.
  assign c_issue_accept_o    = x_issue_accept_i;
  assign c_issue_writeback_o = x_issue_writeback_i;
  assign x_issue_id_o        = c_issue_id_i;
  assign x_commit_valid_o    = c_commit_valid_i;
  assign x_commit_id_o       = c_commit_id_i;
  assign x_commit_kill_o     = c_commit_kill_i;

  // Head of the result FIFO drives the core-side payload.
  assign c_result_id_o   = fifo_id[rd_ptr];
  assign c_result_data_o = fifo_data[rd_ptr];
  assign c_result_rd_o   = fifo_rd[rd_ptr];
  assign c_result_we_o   = fifo_we[rd_ptr];

  assign fifo_full = (fifo_cnt == CW'(RESULT_DEPTH));
  assign fifo_pop  = c_result_valid_o && c_result_ready_i;
  assign res_state = entry_q[x_result_id_i];

  // Issue gate: hold the core off when the tracker is full or the ID is busy.
  always_comb begin
    issue_blocked = (outstanding_o == OW'(NUM_OUTSTANDING)) || (entry_q[c_issue_id_i] != FREE);
    if (issue_blocked) begin
      x_issue_valid_o = 1'b0;
      c_issue_ready_o = 1'b0;
    end else begin
      x_issue_valid_o = c_issue_valid_i;
      c_issue_ready_o = x_issue_ready_i;
    end
    issue_fire  = x_issue_valid_o && x_issue_ready_i && x_issue_accept_i;
    commit_fire = c_commit_valid_i;
  end

  // Result acceptance depends on the registered state of the result's ID.
  always_comb begin
    case (res_state)
      COMMITTED: x_result_ready_o = !fifo_full;
      ISSUED:    x_result_ready_o = 1'b0;
      default:   x_result_ready_o = 1'b1;
    endcase
    res_hs   = x_result_valid_i && x_result_ready_o;
    res_push = res_hs && (res_state == COMMITTED);
    res_drop = res_hs && (res_state == FREE);
  end

  // Next scoreboard state; each transition is keyed on the entry's current state.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      case (entry_q[i])
        FREE: begin
          if (issue_fire && (c_issue_id_i == ID_WIDTH'(i))) entry_d[i] = ISSUED;
          else entry_d[i] = FREE;
        end
        ISSUED: begin
          if (commit_fire && (c_commit_id_i == ID_WIDTH'(i)))
            entry_d[i] = c_commit_kill_i ? FREE : COMMITTED;
          else entry_d[i] = ISSUED;
        end
        COMMITTED: begin
          if (res_push && (x_result_id_i == ID_WIDTH'(i))) entry_d[i] = FREE;
          else entry_d[i] = COMMITTED;
        end
        default: entry_d[i] = FREE;
      endcase
      if (entry_d[i] != FREE) out_next = out_next + OW'(1);
      else out_next = out_next;
    end
  end

  // Scoreboard state, outstanding count and stray-result pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_IDS; i++) entry_q[i] <= FREE;
      outstanding_o  <= '0;
      stray_result_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) entry_q[i] <= entry_d[i];
      outstanding_o  <= out_next;
      stray_result_o <= res_drop;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    case ({res_push, fifo_pop})
      2'b10:   fifo_cnt_next = fifo_cnt + CW'(1);
      2'b01:   fifo_cnt_next = fifo_cnt - CW'(1);
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  // Result FIFO storage, pointers and registered valid flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESULT_DEPTH; i++) begin
        fifo_id[i]   <= '0;
        fifo_data[i] <= '0;
        fifo_rd[i]   <= '0;
        fifo_we[i]   <= 1'b0;
      end
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      c_result_valid_o <= 1'b0;
    end else begin
      if (res_push) begin
        fifo_id[wr_ptr]   <= x_result_id_i;
        fifo_data[wr_ptr] <= x_result_data_i;
        fifo_rd[wr_ptr]   <= x_result_rd_i;
        fifo_we[wr_ptr]   <= x_result_we_i;
        wr_ptr <= (wr_ptr == PW'(RESULT_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= (rd_ptr == PW'(RESULT_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      fifo_cnt         <= fifo_cnt_next;
      c_result_valid_o <= (fifo_cnt_next != '0);
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [TW-1:0] wd_cnt;

      // Watchdog: counts stalled cycles while work is outstanding, pulses and restarts.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wd_cnt    <= '0;
          timeout_o <= 1'b0;
        end else if ((outstanding_o == '0) || res_hs) begin
          wd_cnt    <= '0;
          timeout_o <= 1'b0;
        end else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          wd_cnt    <= '0;
          timeout_o <= 1'b1;
        end else begin
          wd_cnt    <= wd_cnt + TW'(1);
          timeout_o <= 1'b0;
        end
      end
    end else begin : g_no_wd
      // Watchdog disabled: timeout never fires.
      always_ff @(posedge clk_i) begin
        timeout_o <= 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_xif_offload_tracker.sv
// Randomised bench for xif_offload_tracker with a behavioural reference model
// and a result scoreboard checked by an independent monitor process.
module tb_xif_offload_tracker;

  localparam int IDW = 4;
  localparam int NO  = 2;
  localparam int RD  = 2;
  localparam int DW  = 32;
  localparam int TO  = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  logic c_issue_valid_i, c_issue_ready_o, c_issue_accept_o, c_issue_writeback_o;
  logic [IDW-1:0] c_issue_id_i, x_issue_id_o;
  logic x_issue_valid_o, x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i;
  logic c_commit_valid_i, c_commit_kill_i, x_commit_valid_o, x_commit_kill_o;
  logic [IDW-1:0] c_commit_id_i, x_commit_id_o;
  logic x_result_valid_i, x_result_ready_o, x_result_we_i;
  logic [IDW-1:0] x_result_id_i, c_result_id_o;
  logic [DW-1:0] x_result_data_i, c_result_data_o;
  logic [4:0] x_result_rd_i, c_result_rd_o;
  logic c_result_valid_o, c_result_ready_i, c_result_we_o;
  logic [1:0] outstanding_o;
  logic stray_result_o, timeout_o;

  xif_offload_tracker #(
    .ID_WIDTH(IDW), .NUM_OUTSTANDING(NO), .RESULT_DEPTH(RD),
    .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c_issue_valid_i(c_issue_valid_i), .c_issue_ready_o(c_issue_ready_o),
    .c_issue_id_i(c_issue_id_i), .c_issue_accept_o(c_issue_accept_o),
    .c_issue_writeback_o(c_issue_writeback_o),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_id_o(x_issue_id_o), .x_issue_accept_i(x_issue_accept_i),
    .x_issue_writeback_i(x_issue_writeback_i),
    .c_commit_valid_i(c_commit_valid_i), .c_commit_id_i(c_commit_id_i),
    .c_commit_kill_i(c_commit_kill_i),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
    .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
    .c_result_valid_o(c_result_valid_o), .c_result_ready_i(c_result_ready_i),
    .c_result_id_o(c_result_id_o), .c_result_data_o(c_result_data_o),
    .c_result_rd_o(c_result_rd_o), .c_result_we_o(c_result_we_o),
    .outstanding_o(outstanding_o), .stray_result_o(stray_result_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [4:0]     rd;
    logic           we;
  } res_t;

  res_t expq[$];

  // Reference model: 0 = free, 1 = issued, 2 = committed
  int st [16];
  int mfifo;
  int stall_run;
  bit exp_stray, exp_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) st[i] = 0;
    mfifo = 0;
    stall_run = 0;
    exp_stray = 1'b0;
    exp_timeout = 1'b0;
    expq.delete();
  endtask

  // Called with inputs already driven (posedge+1); checks, advances the model, moves to next posedge+1.
  task automatic apply();
    int nonfree, pre[16];
    bit blocked, exp_rr, hs, push, pop;
    #2;
    if (rst_i) begin
      model_reset();
    end else begin
      nonfree = 0;
      for (int i = 0; i < 16; i++) if (st[i] != 0) nonfree++;
      blocked = (nonfree == NO) || (st[c_issue_id_i] != 0);
      case (st[x_result_id_i])
        2: exp_rr = (mfifo < RD);
        1: exp_rr = 1'b0;
        default: exp_rr = 1'b1;
      endcase
      chk("outstanding", 64'(outstanding_o), 64'(nonfree));
      chk("c_result_valid", 64'(c_result_valid_o), 64'(mfifo > 0));
      chk("stray", 64'(stray_result_o), 64'(exp_stray));
      chk("timeout", 64'(timeout_o), 64'(exp_timeout));
      chk("x_issue_valid", 64'(x_issue_valid_o), 64'(!blocked && c_issue_valid_i));
      chk("c_issue_ready", 64'(c_issue_ready_o), 64'(!blocked && x_issue_ready_i));
      chk("issue_passthru", 64'({x_issue_id_o, c_issue_accept_o, c_issue_writeback_o}),
          64'({c_issue_id_i, x_issue_accept_i, x_issue_writeback_i}));
      chk("commit_passthru", 64'({x_commit_valid_o, x_commit_id_o, x_commit_kill_o}),
          64'({c_commit_valid_i, c_commit_id_i, c_commit_kill_i}));
      chk("x_result_ready", 64'(x_result_ready_o), 64'(exp_rr));

      pre = st;
      hs = x_result_valid_i && exp_rr;
      if (!blocked && c_issue_valid_i && x_issue_ready_i && x_issue_accept_i) st[c_issue_id_i] = 1;
      if (c_commit_valid_i && pre[c_commit_id_i] == 1) st[c_commit_id_i] = c_commit_kill_i ? 0 : 2;
      push = hs && (pre[x_result_id_i] == 2);
      if (push) begin
        st[x_result_id_i] = 0;
        expq.push_back('{id: x_result_id_i, data: x_result_data_i, rd: x_result_rd_i, we: x_result_we_i});
      end
      exp_stray = hs && (pre[x_result_id_i] == 0);
      pop = (mfifo > 0) && c_result_ready_i;
      mfifo = mfifo + int'(push) - int'(pop);
      if (nonfree > 0 && !hs) begin
        stall_run++;
        exp_timeout = (stall_run % TO) == 0;
      end else begin
        stall_run = 0;
        exp_timeout = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit iv, input int iid, input bit xr, input bit acc,
                       input bit cv, input int cid, input bit kill,
                       input bit rv, input int rid, input bit cr);
    c_issue_valid_i     = iv;
    c_issue_id_i        = IDW'(iid);
    x_issue_ready_i     = xr;
    x_issue_accept_i    = acc;
    x_issue_writeback_i = 1'($urandom);
    c_commit_valid_i    = cv;
    c_commit_id_i       = IDW'(cid);
    c_commit_kill_i     = kill;
    x_result_valid_i    = rv;
    x_result_id_i       = IDW'(rid);
    x_result_data_i     = $urandom;
    x_result_rd_i       = 5'($urandom);
    x_result_we_i       = 1'($urandom);
    c_result_ready_i    = cr;
    apply();
  endtask

  task automatic idle(input int n, input bit cr);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cr);
  endtask

  // Monitor: compares every result leaving the DUT against the scoreboard queue.
  always @(negedge clk_i) begin
    res_t e;
    if (!rst_i && c_result_valid_o && c_result_ready_i) begin
      n_checks++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got id %0h data %0h with no result expected", c_result_id_o, c_result_data_o);
      end else begin
        e = expq.pop_front();
        if ({c_result_id_o, c_result_data_o, c_result_rd_o, c_result_we_o} !== {e.id, e.data, e.rd, e.we}) begin
          n_fail++;
          $display("FAIL result_payload: got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h",
                   c_result_id_o, c_result_data_o, c_result_rd_o, c_result_we_o,
                   e.id, e.data, e.rd, e.we);
        end
      end
    end
  end

  initial begin
    model_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;

    // Fill the tracker, third issue must be blocked
    drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 2, 1, 0, 0, 1);
    // Killed ID produces a stray result
    drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 5, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 1);
    idle(2, 1);
    // Result held until commit, accepted the cycle after
    drive(1, 4, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    drive(0, 0, 0, 0, 1, 4, 0, 1, 4, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    idle(3, 1);
    // FIFO backpressure with core not ready
    drive(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 7, 1, 1, 1, 6, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 7, 0, 1, 6, 0);
    drive(1, 8, 1, 1, 0, 0, 0, 1, 7, 0);
    drive(0, 0, 0, 0, 1, 8, 0, 1, 8, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
    idle(4, 1);
    // Watchdog: committed ID with no result
    drive(1, 9, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 9, 0, 0, 0, 1);
    idle(20, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 1);
    idle(3, 1);
    // Reset with two outstanding and one buffered result
    drive(1, 10, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
    drive(1, 10, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 11, 1, 1, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    drive(1, 10, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 11, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 11, 1, 0, 0, 1);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      drive(1'($urandom), $urandom_range(0, 7), ($urandom % 4) != 0, ($urandom % 4) != 0,
            ($urandom % 3) == 0, $urandom_range(0, 7), ($urandom % 4) == 0,
            1'($urandom), $urandom_range(0, 7), ($urandom % 3) != 0);
    end
    rst_i = 1'b0;
    idle(8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
